swd_xfer_ctl: RTL and testbench

Transfer sequencer sitting directly upstream of the SWD bit-level interface (swdIF). Accepts one DP/AP transfer command at a time over a valid/ready handshake and drives swdIF's go/idle handshake. Automatically re-issues the transfer on WAIT acks up to a programmable limit. Returns ack, read data, parity error and retry count over a response valid/ready handshake.

---
 rtl/swd_pkg.sv | 17 +
 rtl/swd_xfer_match.sv | 31 +++
 rtl/swd_xfer_ctl.sv | 202 ++++++++++++++++++++
 tb/tb_swd_xfer_ctl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swd_pkg.sv
// Shared SWD definitions: ack codes and the transfer-sequencer state encoding
// (also intended for swdIF trace tooling).
package swd_pkg;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_BUSY   = 3'd2,
    S_EVAL   = 3'd3,
    S_RESP   = 3'd4
  } swd_xfer_state_e;

endpackage

// File: rtl/swd_xfer_match.sv
// Value-match helper for swd_xfer_ctl: masked compare of read data and a
// saturating match re-issue counter. Only used when SWD_XFER_MATCH_EN is defined.
module swd_xfer_match #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [31:0]      i_dread,
  input  logic [31:0]      i_mask,
  input  logic [31:0]      i_value,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_miss,
  output logic             o_can_retry
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_miss      = (i_dread & i_mask) != i_value;
  assign o_can_retry = r_cnt < i_limit;

endmodule

// File: rtl/swd_xfer_ctl.sv
// SWD transfer sequencer: one DP/AP command at a time, WAIT re-issue up to a limit.
// Optional value-match reads are enabled by defining SWD_XFER_MATCH_EN.
module swd_xfer_ctl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] wait_retry,
  input  logic             abort,
`ifdef SWD_XFER_MATCH_EN
  input  logic [CNT_W-1:0] match_retry,
  input  logic             cmd_match,
  input  logic [31:0]      cmd_mask,
  input  logic [31:0]      cmd_value,
  output logic             rsp_mismatch,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_apndp,
  input  logic             cmd_rnw,
  input  logic [1:0]       cmd_addr32,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_ack,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_perr,
  output logic [CNT_W-1:0] rsp_retries,
  output logic             swd_go,
  output logic             swd_apndp,
  output logic             swd_rnw,
  output logic [1:0]       swd_addr32,
  output logic [31:0]      swd_dwrite,
  input  logic             swd_idle,
  input  logic [2:0]       swd_ack,
  input  logic [31:0]      swd_dread,
  input  logic             swd_perr
);
  import swd_pkg::*;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  swd_xfer_state_e  r_state, w_state_nxt;
  logic             w_accept, w_retry_wait, w_retry_match, w_latch_rsp;
  logic             w_match_hit, w_match_can;
  logic             w_rd_ok;
  logic             r_cmd_ready, r_go, r_rsp_valid;
  logic [CNT_W-1:0] r_wait_cnt, r_retries;
  logic             r_apndp, r_rnw;
  logic [1:0]       r_addr;
  logic [31:0]      r_wdata;
  logic [2:0]       r_rsp_ack;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_perr;
  logic [CNT_W-1:0] r_rsp_retries;

  assign w_rd_ok = r_rnw && (swd_ack == ACK_OK);

`ifdef SWD_XFER_MATCH_EN
  logic        r_match, r_mismatch;
  logic [31:0] r_mask, r_value;
  logic        w_miss, w_can_retry;

  swd_xfer_match #(.CNT_W(CNT_W)) u_match (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_accept),
    .i_inc      (w_retry_match),
    .i_dread    (swd_dread),
    .i_mask     (r_mask),
    .i_value    (r_value),
    .i_limit    (match_retry),
    .o_miss     (w_miss),
    .o_can_retry(w_can_retry)
  );

  assign w_match_hit = r_match && w_rd_ok && !swd_perr && w_miss;
  assign w_match_can = w_can_retry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_match    <= 1'b0;
      r_mask     <= '0;
      r_value    <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_accept) begin
        r_match <= cmd_match;
        r_mask  <= cmd_mask;
        r_value <= cmd_value;
      end
      if (w_latch_rsp) r_mismatch <= w_match_hit;
    end
  end

  assign rsp_mismatch = r_mismatch;
`else
  assign w_match_hit = 1'b0;
  assign w_match_can = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_retry_wait  = 1'b0;
    w_retry_match = 1'b0;
    w_latch_rsp   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      // swd_idle already low here counts as started (cooling overlap)
      S_LAUNCH: if (!swd_idle) w_state_nxt = S_BUSY;
      S_BUSY:   if (swd_idle)  w_state_nxt = S_EVAL;
      S_EVAL: begin
        if ((swd_ack == ACK_WAIT) && (r_wait_cnt < wait_retry) && !abort) begin
          w_retry_wait = 1'b1;
          w_state_nxt  = S_LAUNCH;
        end else if (w_match_hit && w_match_can && !abort) begin
          w_retry_match = 1'b1;
          w_state_nxt   = S_LAUNCH;
        end else begin
          w_latch_rsp = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_ready <= 1'b0;
      r_go        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_wait_cnt  <= '0;
      r_retries   <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_go        <= (w_state_nxt == S_LAUNCH);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      if (w_accept) begin
        r_wait_cnt <= '0;
        r_retries  <= '0;
      end else begin
        if (w_retry_wait) r_wait_cnt <= sat_inc(r_wait_cnt);
        if (w_retry_wait || w_retry_match) r_retries <= sat_inc(r_retries);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_apndp       <= 1'b0;
      r_rnw         <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rsp_ack     <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_perr    <= 1'b0;
      r_rsp_retries <= '0;
    end else begin
      if (w_accept) begin
        r_apndp <= cmd_apndp;
        r_rnw   <= cmd_rnw;
        r_addr  <= cmd_addr32;
        r_wdata <= cmd_wdata;
      end
      if (w_latch_rsp) begin
        r_rsp_ack     <= swd_ack;
        r_rsp_rdata   <= w_rd_ok ? swd_dread : 32'h0;
        r_rsp_perr    <= w_rd_ok && swd_perr;
        r_rsp_retries <= r_retries;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_ack     = r_rsp_ack;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_perr    = r_rsp_perr;
  assign rsp_retries = r_rsp_retries;
  assign swd_go      = r_go;
  assign swd_apndp   = r_apndp;
  assign swd_rnw     = r_rnw;
  assign swd_addr32  = r_addr;
  assign swd_dwrite  = r_wdata;

endmodule

// File: tb/tb_swd_xfer_ctl.sv
// Randomized self-checking bench for swd_xfer_ctl with a behavioural swdIF model
// and a per-transfer outcome model. Define SWD_XFER_MATCH_EN to cover value-match reads.
module tb_swd_xfer_ctl;
  import swd_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] wait_retry;
  logic             abort;
  logic             cmd_valid, cmd_ready, cmd_apndp, cmd_rnw;
  logic [1:0]       cmd_addr32;
  logic [31:0]      cmd_wdata;
  logic             rsp_valid, rsp_ready;
  logic [2:0]       rsp_ack;
  logic [31:0]      rsp_rdata;
  logic             rsp_perr;
  logic [CNT_W-1:0] rsp_retries;
  logic             swd_go, swd_apndp, swd_rnw;
  logic [1:0]       swd_addr32;
  logic [31:0]      swd_dwrite;
  logic             swd_idle;
  logic [2:0]       swd_ack;
  logic [31:0]      swd_dread;
  logic             swd_perr;
  logic             m_en;
  logic [31:0]      m_mask, m_value;
  logic [CNT_W-1:0] m_retry;
`ifdef SWD_XFER_MATCH_EN
  logic             rsp_mismatch;
`endif

  typedef struct {
    logic [2:0]  ack;
    logic [31:0] data;
    logic        perr;
  } att_t;

  att_t plan[$];
  att_t mq[$];
  int   launches;
  int   underflow;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  swd_xfer_ctl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wait_retry  (wait_retry),
    .abort       (abort),
`ifdef SWD_XFER_MATCH_EN
    .match_retry (m_retry),
    .cmd_match   (m_en),
    .cmd_mask    (m_mask),
    .cmd_value   (m_value),
    .rsp_mismatch(rsp_mismatch),
`endif
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_apndp   (cmd_apndp),
    .cmd_rnw     (cmd_rnw),
    .cmd_addr32  (cmd_addr32),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_ack     (rsp_ack),
    .rsp_rdata   (rsp_rdata),
    .rsp_perr    (rsp_perr),
    .rsp_retries (rsp_retries),
    .swd_go      (swd_go),
    .swd_apndp   (swd_apndp),
    .swd_rnw     (swd_rnw),
    .swd_addr32  (swd_addr32),
    .swd_dwrite  (swd_dwrite),
    .swd_idle    (swd_idle),
    .swd_ack     (swd_ack),
    .swd_dread   (swd_dread),
    .swd_perr    (swd_perr)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // swdIF model: takes go while idle, goes busy for a random time, returns the next planned attempt
  initial begin
    att_t a;
    int   d;
    swd_idle  = 1'b1;
    swd_ack   = 3'b000;
    swd_dread = 32'h0;
    swd_perr  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        swd_idle = 1'b1;
      end else if (swd_go && swd_idle) begin
        launches++;
        if (mq.size() == 0) begin
          underflow++;
          a.ack = ACK_OK; a.data = 32'h0; a.perr = 1'b0;
        end else begin
          a = mq.pop_front();
        end
        d = $urandom_range(0, 2);
        while (d > 0 && !rst) begin @(negedge clk); d--; end
        if (!rst) begin
          swd_idle  = 1'b0;
          swd_ack   = 3'b111;
          swd_dread = $urandom;
          swd_perr  = 1'b1;
          d = $urandom_range(1, 4);
        end
        while (d > 0 && !rst) begin @(negedge clk); d--; end
        if (!rst) begin
          swd_ack   = a.ack;
          swd_dread = a.data;
          swd_perr  = a.perr;
        end
        swd_idle = 1'b1;
      end
    end
  end

  task automatic add(input logic [2:0] ack, input logic [31:0] data, input logic perr);
    att_t a;
    a.ack = ack; a.data = data; a.perr = perr;
    plan.push_back(a);
  endtask

  // One complete transfer; expected outcome derived from the attempt plan
  task automatic run_xfer(input logic apndp, input logic rnw, input logic [1:0] addr,
                          input logic [31:0] wdata, input logic [CNT_W-1:0] wr,
                          input logic ab, input int hold);
    int          k, wk, mk, t;
    att_t        a;
    logic [2:0]  e_ack;
    logic [31:0] e_rd;
    logic        e_perr, e_mm, e_ok;
    k = 0; wk = 0; mk = 0;
    while (k < plan.size() - 1) begin
      a = plan[k];
      if (a.ack == ACK_WAIT && wk < int'(wr) && !ab) begin
        wk++; k++;
      end else if (m_en && rnw && a.ack == ACK_OK && !a.perr &&
                   ((a.data & m_mask) != m_value) && mk < int'(m_retry) && !ab) begin
        mk++; k++;
      end else begin
        break;
      end
    end
    a      = plan[k];
    e_ack  = a.ack;
    e_ok   = rnw && (a.ack == ACK_OK);
    e_rd   = e_ok ? a.data : 32'h0;
    e_perr = e_ok && a.perr;
    e_mm   = m_en && e_ok && !a.perr && ((a.data & m_mask) != m_value);
    mq = plan;
    plan.delete();
    launches   = 0;
    underflow  = 0;
    wait_retry = wr;
    abort      = ab;

    @(negedge clk);
    cmd_apndp = apndp; cmd_rnw = rnw; cmd_addr32 = addr; cmd_wdata = wdata;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk("cmd_ready_wait", 64'(t < 50), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_apndp = 1'($urandom); cmd_rnw = 1'($urandom);
    cmd_addr32 = 2'($urandom); cmd_wdata = $urandom;
    chk("go_after_accept", 64'(swd_go), 64'd1);
    chk("ready_drop", 64'(cmd_ready), 64'd0);

    t = 0;
    while (!rsp_valid && t < 400) begin @(negedge clk); t++; end
    chk("rsp_valid_wait", 64'(rsp_valid), 64'd1);
    chk("rsp_ack", 64'(rsp_ack), 64'(e_ack));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
    chk("rsp_perr", 64'(rsp_perr), 64'(e_perr));
    chk("rsp_retries", 64'(rsp_retries), 64'(k));
    chk("launches", 64'(launches), 64'(k + 1));
    chk("underflow", 64'(underflow), 64'd0);
    chk("swd_cmd", {swd_apndp, swd_rnw, swd_addr32, swd_dwrite}, {apndp, rnw, addr, wdata});
`ifdef SWD_XFER_MATCH_EN
    chk("rsp_mismatch", 64'(rsp_mismatch), 64'(e_mm));
`else
    if (e_mm) chk("match_model_off", 64'(e_mm), 64'd0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_ctl", {rsp_valid, cmd_ready, swd_go, rsp_ack, rsp_perr},
          {1'b1, 1'b0, 1'b0, e_ack, e_perr});
      chk("hold_data", {rsp_rdata, rsp_retries}, {e_rd, CNT_W'(k)});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    chk("ready_b2b", 64'(cmd_ready), 64'd1);
    abort = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {cmd_ready, swd_go, rsp_valid, swd_apndp, swd_rnw, swd_addr32,
                        rsp_ack, rsp_perr, rsp_retries}, 64'd0);
    chk({tag, "_data"}, {rsp_rdata, swd_dwrite}, 64'd0);
  endtask

  initial begin
    logic [2:0] others[5];
    int         t;
    others = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    rst = 1'b1; wait_retry = '0; abort = 1'b0;
    cmd_valid = 1'b0; cmd_apndp = 1'b0; cmd_rnw = 1'b0; cmd_addr32 = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    m_en = 1'b0; m_mask = '0; m_value = '0; m_retry = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    chk("ready_in_rst", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // AP write, OK
    add(ACK_OK, 32'h1234_5678, 1'b0);
    run_xfer(1'b1, 1'b0, 2'b01, 32'hDEADBEEF, 16'd0, 1'b0, 0);
    // DP read, WAIT x3 then OK
    repeat (3) add(ACK_WAIT, 32'hFFFF_0000, 1'b0);
    add(ACK_OK, 32'h2BA01477, 1'b0);
    run_xfer(1'b0, 1'b1, 2'b00, 32'h0, 16'd5, 1'b0, 1);
    // WAIT exhaustion, then abort wins on first WAIT
    repeat (5) add(ACK_WAIT, 32'h0, 1'b0);
    run_xfer(1'b1, 1'b1, 2'b11, 32'h0, 16'd2, 1'b0, 0);
    repeat (5) add(ACK_WAIT, 32'h0, 1'b0);
    run_xfer(1'b1, 1'b1, 2'b11, 32'h0, 16'd2, 1'b1, 0);
    // FAULT, then parity error read, with a long response stall
    add(ACK_FAULT, 32'hAAAA_5555, 1'b0);
    add(ACK_OK, 32'h0, 1'b0);
    run_xfer(1'b0, 1'b1, 2'b10, 32'h0, 16'd5, 1'b0, 0);
    add(ACK_OK, 32'h0, 1'b1);
    add(ACK_OK, 32'h1, 1'b0);
    run_xfer(1'b1, 1'b1, 2'b01, 32'h0, 16'd5, 1'b0, 10);
`ifdef SWD_XFER_MATCH_EN
    m_en = 1'b1; m_mask = 32'h1; m_value = 32'h1; m_retry = 16'd4;
    add(ACK_OK, 32'h0, 1'b0); add(ACK_OK, 32'h0, 1'b0); add(ACK_OK, 32'h1, 1'b0);
    run_xfer(1'b1, 1'b1, 2'b00, 32'h0, 16'd0, 1'b0, 0);
    m_en = 1'b0;
`endif

    // Reset while the transfer is in flight
    add(ACK_OK, 32'h5555_AAAA, 1'b0);
    mq = plan; plan.delete();
    @(negedge clk);
    cmd_apndp = 1'b1; cmd_rnw = 1'b1; cmd_addr32 = 2'b10; cmd_wdata = 32'hCAFE_F00D;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (swd_idle && t < 20) begin @(negedge clk); t++; end
    chk("busy_seen", 64'(swd_idle), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready0", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("mid_rst_ready1", 64'(cmd_ready), 64'd1);
    mq.delete();

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 10; j++) begin
        int r;
        logic [2:0] ack;
        r = $urandom_range(0, 9);
        if (r < 5)      ack = ACK_WAIT;
        else if (r < 8) ack = ACK_OK;
        else if (r < 9) ack = ACK_FAULT;
        else            ack = others[$urandom_range(0, 4)];
        add(ack, $urandom, ($urandom_range(0, 4) == 0));
      end
`ifdef SWD_XFER_MATCH_EN
      m_en = 1'($urandom); m_mask = 32'h3;
      m_value = 32'($urandom_range(0, 3)); m_retry = CNT_W'($urandom_range(0, 3));
`endif
      run_xfer(1'($urandom), 1'($urandom), 2'($urandom), $urandom,
               CNT_W'($urandom_range(0, 4)), ($urandom_range(0, 9) == 0),
               $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
